// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-sequencer bundle (imem req/ack, decode valid/ready, branch resolution, link write, stats)
interface pc_fetch_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    instr_pc;
  logic               br_valid;
  logic               do_branch;
  logic               br_sel_reg;
  logic [PC_W-1:0]    br_imm_target;
  logic [PC_W-1:0]    br_reg_target;
  logic               br_link;
  logic [PC_W-1:0]    br_pc;
  logic               link_we;
  logic [PC_W-1:0]    link_addr;
  logic [31:0]        taken_cnt;
  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc, link_we, link_addr, taken_cnt,
    input  imem_ack, imem_rdata, instr_ready, br_valid, do_branch, br_sel_reg,
           br_imm_target, br_reg_target, br_link, br_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, link_we, link_addr, taken_cnt,
    output imem_ack, imem_rdata, instr_ready, br_valid, do_branch, br_sel_reg,
           br_imm_target, br_reg_target, br_link, br_pc
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: KGP-RISC PC holder, imem fetch sequencer, branch redirect and bl link write.
// Define BRANCH_STATS_EN to build the taken-branch counter; otherwise taken_cnt is tied to 0.
module pc_fetch_sequencer #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic       clk,
  input logic       rst,
  pc_fetch_if.master bus
);
  localparam logic [1:0] S_REQ    = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_SQUASH = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, addr_q, addr_d, ipc_q, ipc_d, laddr_q, laddr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               link_q, link_d, taken;
  logic [PC_W-1:0]    target;
  assign taken   = bus.br_valid & bus.do_branch;
  assign target  = (bus.br_sel_reg ? bus.br_reg_target : bus.br_imm_target) & ~PC_W'(3);
  assign link_d  = taken & bus.br_link;
  assign laddr_d = bus.br_pc + PC_W'(4);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (state_q == S_REQ) begin
      if (taken) begin
        pc_d    = target;
        addr_d  = pc_q;
        state_d = bus.imem_ack ? S_REQ : S_SQUASH;
      end else if (bus.imem_ack) begin
        instr_d = bus.imem_rdata;
        ipc_d   = pc_q;
        state_d = S_HOLD;
      end
    end else if (state_q == S_HOLD) begin
      if (taken || bus.instr_ready) begin
        pc_d    = taken ? target : pc_q + PC_W'(4);
        state_d = S_REQ;
      end
    end else begin
      pc_d    = taken ? target : pc_q;
      state_d = bus.imem_ack ? S_REQ : S_SQUASH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      link_q  <= 1'b0;
      laddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      link_q  <= link_d;
      laddr_q <= laddr_d;
    end
  end
  // a squashed request keeps its original address until the memory acks it
  assign bus.imem_req    = ~rst & (state_q != S_HOLD);
  assign bus.imem_addr   = (state_q == S_SQUASH) ? addr_q : pc_q;
  assign bus.instr_valid = state_q == S_HOLD;
  assign bus.instr_out   = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.link_we     = link_q;
  assign bus.link_addr   = laddr_q;
`ifdef BRANCH_STATS_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = taken ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk) begin
    cnt_q <= rst ? 32'd0 : cnt_d;
  end
  assign bus.taken_cnt = cnt_q;
`else
  assign bus.taken_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: randomized and directed checks of pc_fetch_sequencer against a program-level PC model.
module tb_pc_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pc_fetch_if #(.PC_W(32), .INSTR_W(32)) bus ();
  pc_fetch_sequencer #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int lat = 0;
  int wcnt = 0;
  logic [31:0] e_pc = 0, e_laddr = 0, e_cnt = 0, prev_addr = 0;
  logic        e_link = 0, prev_stall = 0;
  logic [31:0] fetched[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // one clock: memory responder plus program-level model of the next instruction address
  task automatic tick();
    logic tk, r;
    logic [31:0] npc;
    #1;
    r  = rst;
    tk = bus.br_valid & bus.do_branch;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    if (bus.imem_req) begin
      if (wcnt >= lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = memf(bus.imem_addr);
        fetched.push_back(bus.imem_addr);
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
    prev_stall = bus.imem_req & ~bus.imem_ack;
    prev_addr  = bus.imem_addr;
    npc = tk ? ((bus.br_sel_reg ? bus.br_reg_target : bus.br_imm_target) & ~32'd3)
             : (bus.instr_valid & bus.instr_ready) ? e_pc + 32'd4 : e_pc;
    e_link  = tk & bus.br_link;
    e_laddr = bus.br_pc + 32'd4;
    if (tk) e_cnt++;
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    if (r) begin
      npc = 0; e_link = 0; e_cnt = 0; wcnt = 0; prev_stall = 0;
    end
    e_pc = npc;
  endtask

  task automatic clr_br();
    bus.br_valid = 0; bus.do_branch = 0; bus.br_sel_reg = 0; bus.br_link = 0;
    bus.br_imm_target = 0; bus.br_reg_target = 0; bus.br_pc = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic go_hold(input logic [31:0] a);
    bit hit = 0;
    lat = 0;
    do_reset();
    bus.instr_ready = 1;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (bus.instr_valid && bus.instr_pc == a) hit = 1;
    end
    bus.instr_ready = 0;
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL go_hold: pc 0x%0h never presented, last instr_pc=0x%0h", a, bus.instr_pc); end
  endtask

  task automatic wait_valid(input int n);
    for (int i = 0; i < n && !bus.instr_valid; i++) tick();
  endtask

  task automatic test_sequential();
    int k = 0;
    int cyc[4];
    logic [31:0] pcs[4];
    do_reset();
    lat = 0; bus.instr_ready = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.instr_valid) begin
        if (k < 4) begin pcs[k] = bus.instr_pc; cyc[k] = c; end
        k++;
      end
    end
    bus.instr_ready = 0;
    n_cmp++;
    if (k !== 4) begin n_bad++; $display("FAIL seq_count: got %0d instrs want 4", k); end
    for (int i = 0; i < 4 && i < k; i++) begin
      n_cmp++;
      if (pcs[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_pc[%0d]: got 0x%0h want 0x%0h", i, pcs[i], 4 * i); end
      if (i > 0) begin
        n_cmp++;
        if (cyc[i] - cyc[i-1] !== 2) begin n_bad++; $display("FAIL seq_rate[%0d]: gap %0d want 2", i, cyc[i] - cyc[i-1]); end
      end
    end
  endtask

  task automatic test_reset();
    lat = 3; bus.instr_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1;
    tick(); tick();
    n_cmp++;
    if (bus.imem_req !== 0 || bus.instr_valid !== 0 || bus.link_we !== 0) begin
      n_bad++; $display("FAIL reset_ctl: req=%b valid=%b link_we=%b want 0 0 0", bus.imem_req, bus.instr_valid, bus.link_we);
    end
    n_cmp++;
    if (bus.instr_out !== 0 || bus.instr_pc !== 0 || bus.taken_cnt !== 0 || bus.imem_addr !== 0) begin
      n_bad++; $display("FAIL reset_val: out=0x%0h pc=0x%0h cnt=%0d addr=0x%0h want all 0", bus.instr_out, bus.instr_pc, bus.taken_cnt, bus.imem_addr);
    end
    rst = 0; bus.instr_ready = 0; lat = 0;
    #1;
    n_cmp++;
    if (bus.imem_req !== 1 || bus.imem_addr !== 0) begin
      n_bad++; $display("FAIL reset_release: req=%b addr=0x%0h want 1 0x0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_branch_hold();
    bit bad_fetch = 0;
    go_hold(32'h10);
    fetched.delete();
    bus.br_valid = 1; bus.do_branch = 1; bus.br_imm_target = 32'h40;
    tick();
    clr_br();
    n_cmp++;
    if (bus.instr_valid !== 0 || bus.imem_req !== 1 || bus.imem_addr !== 32'h40) begin
      n_bad++; $display("FAIL hold_branch: valid=%b req=%b addr=0x%0h want 0 1 0x40", bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    wait_valid(20);
    n_cmp++;
    if (bus.instr_valid !== 1 || bus.instr_pc !== 32'h40 || bus.instr_out !== memf(32'h40)) begin
      n_bad++; $display("FAIL hold_target: valid=%b pc=0x%0h out=0x%0h want 1 0x40 0x%0h", bus.instr_valid, bus.instr_pc, bus.instr_out, memf(32'h40));
    end
    foreach (fetched[i]) if (fetched[i] == 32'h14) bad_fetch = 1;
    n_cmp++;
    if (bad_fetch) begin n_bad++; $display("FAIL hold_nofetch: got fetch of 0x14 want none"); end
  endtask

  task automatic test_squash();
    int stay = 0;
    bit saw_valid = 0;
    go_hold(32'h1c);
    lat = 3; bus.instr_ready = 1;
    tick();
    bus.instr_ready = 0;
    n_cmp++;
    if (bus.imem_req !== 1 || bus.imem_addr !== 32'h20) begin
      n_bad++; $display("FAIL squash_pre: req=%b addr=0x%0h want 1 0x20", bus.imem_req, bus.imem_addr);
    end
    fetched.delete();
    bus.br_valid = 1; bus.do_branch = 1; bus.br_imm_target = 32'h80;
    tick();
    clr_br();
    while (bus.imem_req && bus.imem_addr == 32'h20 && stay < 10) begin
      if (bus.instr_valid) saw_valid = 1;
      tick();
      stay++;
    end
    n_cmp++;
    if (stay !== 3 || saw_valid) begin
      n_bad++; $display("FAIL squash_hold: addr 0x20 held %0d cycles valid_seen=%b want 3 0", stay, saw_valid);
    end
    n_cmp++;
    if (bus.imem_req !== 1 || bus.imem_addr !== 32'h80 || fetched.size() < 1 || fetched[0] !== 32'h20) begin
      n_bad++; $display("FAIL squash_redirect: req=%b addr=0x%0h want 1 0x80", bus.imem_req, bus.imem_addr);
    end
    lat = 0;
    wait_valid(20);
    n_cmp++;
    if (bus.instr_valid !== 1 || bus.instr_pc !== 32'h80 || bus.instr_out !== memf(32'h80)) begin
      n_bad++; $display("FAIL squash_target: valid=%b pc=0x%0h want 1 0x80", bus.instr_valid, bus.instr_pc);
    end
  endtask

  task automatic test_link();
    go_hold(32'h30);
    bus.br_valid = 1; bus.do_branch = 1; bus.br_link = 1; bus.br_pc = 32'h30; bus.br_imm_target = 32'h100;
    tick();
    clr_br();
    n_cmp++;
    if (bus.link_we !== 1 || bus.link_addr !== 32'h34 || bus.imem_addr !== 32'h100) begin
      n_bad++; $display("FAIL bl_pulse: link_we=%b link_addr=0x%0h addr=0x%0h want 1 0x34 0x100", bus.link_we, bus.link_addr, bus.imem_addr);
    end
    tick();
    n_cmp++;
    if (bus.link_we !== 0) begin n_bad++; $display("FAIL bl_once: link_we=%b want 0", bus.link_we); end
    go_hold(32'h30);
    bus.br_valid = 1; bus.do_branch = 0; bus.br_link = 1; bus.br_pc = 32'h30; bus.br_imm_target = 32'h100;
    tick();
    clr_br();
    n_cmp++;
    if (bus.link_we !== 0 || bus.instr_valid !== 1 || bus.instr_pc !== 32'h30) begin
      n_bad++; $display("FAIL bl_nottaken: link_we=%b valid=%b pc=0x%0h want 0 1 0x30", bus.link_we, bus.instr_valid, bus.instr_pc);
    end
    bus.instr_ready = 1;
    tick();
    bus.instr_ready = 0;
    n_cmp++;
    if (bus.imem_addr !== 32'h34 || bus.link_we !== 0) begin
      n_bad++; $display("FAIL bl_nt_next: addr=0x%0h link_we=%b want 0x34 0", bus.imem_addr, bus.link_we);
    end
  endtask

  task automatic test_reg_target();
    go_hold(32'h10);
    bus.br_valid = 1; bus.do_branch = 1; bus.br_sel_reg = 1; bus.br_reg_target = 32'h203; bus.br_imm_target = 32'h40;
    bus.instr_ready = 1;
    tick();
    clr_br();
    bus.instr_ready = 0;
    n_cmp++;
    if (bus.imem_addr !== 32'h200 || bus.instr_valid !== 0) begin
      n_bad++; $display("FAIL reg_target: addr=0x%0h valid=%b want 0x200 0", bus.imem_addr, bus.instr_valid);
    end
    wait_valid(20);
    n_cmp++;
    if (bus.instr_valid !== 1 || bus.instr_pc !== 32'h200) begin
      n_bad++; $display("FAIL reg_deliver: valid=%b pc=0x%0h want 1 0x200", bus.instr_valid, bus.instr_pc);
    end
  endtask

  task automatic test_stats();
    bit pat[8];
    for (int i = 0; i < 8; i++) pat[i] = (i < 5);
    for (int i = 0; i < 8; i++) begin
      int j = $urandom_range(0, 7);
      bit t = pat[i];
      pat[i] = pat[j]; pat[j] = t;
    end
    do_reset();
    lat = 0; bus.instr_ready = 1;
    for (int i = 0; i < 8; i++) begin
      bus.br_valid = 1; bus.do_branch = pat[i]; bus.br_imm_target = $urandom & 32'hffc;
      tick();
      clr_br();
      tick();
    end
    bus.instr_ready = 0;
    n_cmp++;
    if (bus.taken_cnt !== (STATS ? 32'd5 : 32'd0)) begin
      n_bad++; $display("FAIL stats_count: got %0d want %0d", bus.taken_cnt, STATS ? 5 : 0);
    end
    rst = 1; tick(); rst = 0;
    n_cmp++;
    if (bus.taken_cnt !== 0) begin n_bad++; $display("FAIL stats_clear: got %0d want 0", bus.taken_cnt); end
  endtask

  task automatic test_random();
    int delivered = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) lat = $urandom_range(0, 3);
      bus.instr_ready   = $urandom_range(0, 1);
      bus.br_valid      = ($urandom_range(0, 5) == 0);
      bus.do_branch     = $urandom_range(0, 1);
      bus.br_sel_reg    = $urandom_range(0, 1);
      bus.br_link       = $urandom_range(0, 1);
      bus.br_imm_target = $urandom;
      bus.br_reg_target = $urandom;
      bus.br_pc         = $urandom;
      tick();
      n_cmp++;
      if (prev_stall && (bus.imem_req !== 1 || bus.imem_addr !== prev_addr)) begin
        n_bad++; $display("FAIL rnd_addr_stable c=%0d: req=%b addr=0x%0h want 1 0x%0h", c, bus.imem_req, bus.imem_addr, prev_addr);
      end
      if (bus.instr_valid) begin
        delivered++;
        n_cmp++;
        if (bus.instr_pc !== e_pc || bus.instr_out !== memf(e_pc)) begin
          n_bad++; $display("FAIL rnd_instr c=%0d: pc=0x%0h out=0x%0h want 0x%0h 0x%0h", c, bus.instr_pc, bus.instr_out, e_pc, memf(e_pc));
        end
      end
      n_cmp++;
      if (bus.link_we !== e_link || (e_link && bus.link_addr !== e_laddr)) begin
        n_bad++; $display("FAIL rnd_link c=%0d: we=%b addr=0x%0h want %b 0x%0h", c, bus.link_we, bus.link_addr, e_link, e_laddr);
      end
      n_cmp++;
      if (bus.taken_cnt !== (STATS ? e_cnt : 32'd0)) begin
        n_bad++; $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, bus.taken_cnt, STATS ? e_cnt : 32'd0);
      end
    end
    clr_br();
    bus.instr_ready = 0;
    n_cmp++;
    if (delivered < 20) begin n_bad++; $display("FAIL rnd_progress: delivered %0d want >=20", delivered); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.instr_ready = 0;
    clr_br();
    do_reset();
    test_sequential();
    test_reset();
    test_branch_hold();
    test_squash();
    test_link();
    test_reg_target();
    test_stats();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
